// File: rtl/homography_warp.sv
// rtl/homography_warp.sv - programmable 3x3 fixed-point homography pixel fetch with bounds check and fill colour
module homography_warp #(
    parameter int             COORD_W = 10,
    parameter int             COEF_W  = 16,
    parameter int             FRAC_W  = 8,
    parameter int             SRC_W   = 640,
    parameter int             SRC_H   = 480,
    parameter logic [4:0]     FILL_R  = 5'd0,
    parameter logic [5:0]     FILL_G  = 6'd0,
    parameter logic [4:0]     FILL_B  = 5'd0
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic               iCOEF_WE,
    input  logic [3:0]         iCOEF_ADDR,
    input  logic [COEF_W-1:0]  iCOEF_DATA,
    input  logic               iSTART,
    input  logic [COORD_W-1:0] iX,
    input  logic [COORD_W-1:0] iY,
    output logic               oBUSY,
    output logic               oREQ,
    output logic [COORD_W-1:0] oSRAM_X,
    output logic [COORD_W-1:0] oSRAM_Y,
    input  logic               iREADY,
    input  logic [4:0]         iR,
    input  logic [5:0]         iG,
    input  logic [4:0]         iB,
    output logic [COORD_W-1:0] oCON_X,
    output logic [COORD_W-1:0] oCON_Y,
    output logic [4:0]         oR,
    output logic [5:0]         oG,
    output logic [4:0]         oB,
    output logic               oREADY,
    output logic               oOOB
);
    localparam int NUM_W = COEF_W + COORD_W + 2;
    localparam int CNT_W = $clog2(NUM_W + 1);
    localparam logic [COEF_W-1:0] ONE = COEF_W'(1 << FRAC_W);

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_CHK, S_REQ, S_OUT} state_t;

    state_t             state;
    logic [COEF_W-1:0]  shadow [9];
    logic [COEF_W-1:0]  active [9];
    logic [COORD_W-1:0] lat_x, lat_y;
    logic [NUM_W-1:0]   qx, qy, den;
    logic [NUM_W-1:0]   rx, ry;
    logic               neg_x, neg_y, dzero;
    logic [CNT_W-1:0]   cnt;

    function automatic logic signed [NUM_W-1:0] mac(
        input logic [COEF_W-1:0]  a,
        input logic [COEF_W-1:0]  b,
        input logic [COEF_W-1:0]  c,
        input logic [COORD_W-1:0] x,
        input logic [COORD_W-1:0] y
    );
        logic signed [NUM_W-1:0] ae, be, ce, xe, ye;
        ae = {{(NUM_W-COEF_W){a[COEF_W-1]}}, a};
        be = {{(NUM_W-COEF_W){b[COEF_W-1]}}, b};
        ce = {{(NUM_W-COEF_W){c[COEF_W-1]}}, c};
        xe = {{(NUM_W-COORD_W){1'b0}}, x};
        ye = {{(NUM_W-COORD_W){1'b0}}, y};
        return ae * xe + be * ye + ce;
    endfunction

    function automatic logic [NUM_W-1:0] mag(input logic signed [NUM_W-1:0] v);
        return v[NUM_W-1] ? NUM_W'(-v) : NUM_W'(v);
    endfunction

    logic signed [NUM_W-1:0] nx, ny, dd;
    logic [NUM_W+1:0]        tx, ty;
    logic                    inb_x, inb_y;

    always_comb begin
        nx = mac(active[0], active[1], active[2], lat_x, lat_y);
        ny = mac(active[3], active[4], active[5], lat_x, lat_y);
        dd = mac(active[6], active[7], active[8], lat_x, lat_y);
        // Restoring step: bit NUM_W+1 of the trial difference is the borrow
        tx = {1'b0, rx, qx[NUM_W-1]} - {2'b00, den};
        ty = {1'b0, ry, qy[NUM_W-1]} - {2'b00, den};
        inb_x = !(neg_x && qx != '0) && (qx < NUM_W'(SRC_W));
        inb_y = !(neg_y && qy != '0) && (qy < NUM_W'(SRC_H));
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state   <= S_IDLE;
            for (int i = 0; i < 9; i++) begin
                shadow[i] <= (i == 0 || i == 4 || i == 8) ? ONE : '0;
                active[i] <= (i == 0 || i == 4 || i == 8) ? ONE : '0;
            end
            lat_x   <= '0;
            lat_y   <= '0;
            qx      <= '0;
            qy      <= '0;
            rx      <= '0;
            ry      <= '0;
            den     <= '0;
            neg_x   <= 1'b0;
            neg_y   <= 1'b0;
            dzero   <= 1'b0;
            cnt     <= '0;
            oBUSY   <= 1'b0;
            oREQ    <= 1'b0;
            oSRAM_X <= '0;
            oSRAM_Y <= '0;
            oCON_X  <= '0;
            oCON_Y  <= '0;
            oR      <= '0;
            oG      <= '0;
            oB      <= '0;
            oREADY  <= 1'b0;
            oOOB    <= 1'b0;
        end else begin
            if (iCOEF_WE && iCOEF_ADDR < 4'd9)
                shadow[iCOEF_ADDR] <= iCOEF_DATA;

            case (state)
                S_IDLE: begin
                    if (iSTART) begin
                        for (int i = 0; i < 9; i++) active[i] <= shadow[i];
                        lat_x <= iX;
                        lat_y <= iY;
                        oBUSY <= 1'b1;
                        state <= S_MUL;
                    end
                end
                S_MUL: begin
                    qx    <= mag(nx);
                    qy    <= mag(ny);
                    den   <= mag(dd);
                    rx    <= '0;
                    ry    <= '0;
                    neg_x <= nx[NUM_W-1] ^ dd[NUM_W-1];
                    neg_y <= ny[NUM_W-1] ^ dd[NUM_W-1];
                    dzero <= (dd == '0);
                    cnt   <= '0;
                    state <= S_DIV;
                end
                S_DIV: begin
                    if (!tx[NUM_W+1]) begin
                        rx <= tx[NUM_W-1:0];
                        qx <= {qx[NUM_W-2:0], 1'b1};
                    end else begin
                        rx <= {rx[NUM_W-2:0], qx[NUM_W-1]};
                        qx <= {qx[NUM_W-2:0], 1'b0};
                    end
                    if (!ty[NUM_W+1]) begin
                        ry <= ty[NUM_W-1:0];
                        qy <= {qy[NUM_W-2:0], 1'b1};
                    end else begin
                        ry <= {ry[NUM_W-2:0], qy[NUM_W-1]};
                        qy <= {qy[NUM_W-2:0], 1'b0};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(NUM_W - 1))
                        state <= S_CHK;
                end
                S_CHK: begin
                    if (!dzero && inb_x && inb_y) begin
                        oSRAM_X <= qx[COORD_W-1:0];
                        oSRAM_Y <= qy[COORD_W-1:0];
                        oREQ    <= 1'b1;
                        state   <= S_REQ;
                    end else begin
                        oR     <= FILL_R;
                        oG     <= FILL_G;
                        oB     <= FILL_B;
                        oOOB   <= 1'b1;
                        oCON_X <= lat_x;
                        oCON_Y <= lat_y;
                        oREADY <= 1'b1;
                        state  <= S_OUT;
                    end
                end
                S_REQ: begin
                    if (iREADY) begin
                        oR     <= iR;
                        oG     <= iG;
                        oB     <= iB;
                        oOOB   <= 1'b0;
                        oCON_X <= lat_x;
                        oCON_Y <= lat_y;
                        oREQ   <= 1'b0;
                        oREADY <= 1'b1;
                        state  <= S_OUT;
                    end
                end
                S_OUT: begin
                    oREADY <= 1'b0;
                    oBUSY  <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_homography_warp.sv
// tb/tb_homography_warp.sv - scoreboard bench for homography_warp
module tb_homography_warp;
    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic        iCOEF_WE = 1'b0;
    logic [3:0]  iCOEF_ADDR = '0;
    logic [15:0] iCOEF_DATA = '0;
    logic        iSTART = 1'b0;
    logic [9:0]  iX = '0, iY = '0;
    logic        oBUSY, oREQ, oREADY, oOOB;
    logic [9:0]  oSRAM_X, oSRAM_Y, oCON_X, oCON_Y;
    logic        iREADY = 1'b0;
    logic [4:0]  iR = '0, iB = '0, oR, oB;
    logic [5:0]  iG = '0, oG;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit oob;
        int r, g, b, cx, cy;
    } exp_t;
    exp_t sb[$];

    homography_warp dut (
        .iCLK(iCLK), .iRST(iRST),
        .iCOEF_WE(iCOEF_WE), .iCOEF_ADDR(iCOEF_ADDR), .iCOEF_DATA(iCOEF_DATA),
        .iSTART(iSTART), .iX(iX), .iY(iY),
        .oBUSY(oBUSY), .oREQ(oREQ), .oSRAM_X(oSRAM_X), .oSRAM_Y(oSRAM_Y),
        .iREADY(iREADY), .iR(iR), .iG(iG), .iB(iB),
        .oCON_X(oCON_X), .oCON_Y(oCON_Y), .oR(oR), .oG(oG), .oB(oB),
        .oREADY(oREADY), .oOOB(oOOB)
    );

    always #5 iCLK = ~iCLK;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    always @(negedge iCLK) begin
        if (!iRST && oREADY) begin
            if (sb.size() == 0) begin
                chk("unexpected_oREADY", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("oOOB", int'(oOOB), int'(e.oob));
                chk("oR", int'(oR), e.r);
                chk("oG", int'(oG), e.g);
                chk("oB", int'(oB), e.b);
                chk("oCON_X", int'(oCON_X), e.cx);
                chk("oCON_Y", int'(oCON_Y), e.cy);
            end
        end
    end

    task automatic wcoef(input int addr, input int data);
        @(negedge iCLK);
        iCOEF_WE   = 1'b1;
        iCOEF_ADDR = 4'(addr);
        iCOEF_DATA = 16'(data);
        @(negedge iCLK);
        iCOEF_WE   = 1'b0;
    endtask

    // hold = number of cycles oREQ is expected high before iREADY is captured
    task automatic pixel(input int x, input int y, input bit oob, input int sx, input int sy,
                         input int hold, input int r, input int g, input int b);
        int n;
        int req_cycles;
        sb.push_back('{oob, oob ? 0 : r, oob ? 0 : g, oob ? 0 : b, x, y});
        @(negedge iCLK);
        iSTART = 1'b1;
        iX = 10'(x);
        iY = 10'(y);
        @(posedge iCLK);
        #1 iSTART = 1'b0;
        n = 0;
        while (n < 64) begin
            @(negedge iCLK);
            if (oREQ || oREADY) break;
            n++;
        end
        chk("latency", n, 30);
        if (oob) begin
            chk("no_req_on_oob", int'(oREQ), 0);
            chk("oob_ready", int'(oREADY), 1);
        end else begin
            chk("oSRAM_X", int'(oSRAM_X), sx);
            chk("oSRAM_Y", int'(oSRAM_Y), sy);
            req_cycles = 1;
            for (int j = 1; j < hold; j++) begin
                @(negedge iCLK);
                if (oREQ) req_cycles++;
            end
            iREADY = 1'b1;
            iR = 5'(r);
            iG = 6'(g);
            iB = 5'(b);
            @(negedge iCLK);
            iREADY = 1'b0;
            chk("req_cycles", req_cycles, hold);
            chk("req_dropped", int'(oREQ), 0);
            chk("ready_after_req", int'(oREADY), 1);
        end
        @(negedge iCLK);
        chk("ready_one_cycle", int'(oREADY), 0);
        chk("idle_not_busy", int'(oBUSY), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge iCLK);
        chk("rst_busy", int'(oBUSY), 0);
        chk("rst_req", int'(oREQ), 0);
        chk("rst_ready", int'(oREADY), 0);
        chk("rst_sram_x", int'(oSRAM_X), 0);
        iRST = 1'b0;

        // identity
        pixel(100, 50, 0, 100, 50, 1, 31, 63, 0);

        // scale by 2
        wcoef(0, 512);
        wcoef(4, 512);
        pixel(200, 100, 0, 400, 200, 1, 1, 2, 3);
        pixel(400, 100, 1, 0, 0, 1, 0, 0, 0);

        // translate x by -50.0
        wcoef(0, 256);
        wcoef(4, 256);
        wcoef(2, -12800);
        pixel(30, 10, 1, 0, 0, 1, 0, 0, 0);
        pixel(80, 10, 0, 30, 10, 1, 7, 8, 9);
        wcoef(2, 0);

        // zero divisor, then projective divide by 2 with truncation
        wcoef(8, 0);
        pixel(100, 50, 1, 0, 0, 1, 0, 0, 0);
        wcoef(8, 512);
        wcoef(12, 999);
        pixel(100, 50, 0, 50, 25, 1, 10, 20, 30);
        pixel(101, 51, 0, 50, 25, 1, 11, 21, 31);
        wcoef(8, 256);

        // coefficient write while busy only affects the next pixel
        fork
            pixel(100, 50, 0, 100, 50, 1, 3, 4, 5);
            begin
                repeat (5) @(negedge iCLK);
                wcoef(0, 512);
            end
        join
        pixel(100, 50, 0, 200, 50, 1, 6, 7, 8);
        wcoef(0, 256);

        // slow SRAM, and a stray iSTART while busy
        pixel(60, 70, 0, 60, 70, 5, 17, 33, 12);
        fork
            pixel(20, 30, 0, 20, 30, 1, 2, 4, 6);
            begin
                repeat (8) @(negedge iCLK);
                iSTART = 1'b1;
                iX = 10'd500;
                iY = 10'd400;
                @(negedge iCLK);
                iSTART = 1'b0;
            end
        join

        // reset during DIV
        wcoef(0, 512);
        @(negedge iCLK);
        iSTART = 1'b1;
        iX = 10'd100;
        iY = 10'd50;
        @(negedge iCLK);
        iSTART = 1'b0;
        repeat (10) @(negedge iCLK);
        chk("busy_before_rst", int'(oBUSY), 1);
        iRST = 1'b1;
        #1;
        chk("mid_rst_busy", int'(oBUSY), 0);
        chk("mid_rst_req", int'(oREQ), 0);
        chk("mid_rst_ready", int'(oREADY), 0);
        chk("mid_rst_r", int'(oR), 0);
        chk("mid_rst_g", int'(oG), 0);
        chk("mid_rst_con_x", int'(oCON_X), 0);
        @(negedge iCLK);
        iRST = 1'b0;
        pixel(100, 50, 0, 100, 50, 1, 9, 9, 9);

        repeat (3) @(negedge iCLK);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
